conv_8_32: RTL
==============

Name: conv_8_32

Overview:
- Byte-to-word packer, the receive-side counterpart of the 32-to-8 serializer in the Manejo_bits path.
- Accepts one qualified 8-bit byte per clk4f cycle.
- Assembles four bytes, first received byte into the MSB, into a 32-bit word.
- Presents the word with a one-cycle valid pulse.
- A gap watchdog discards stale partial words so the byte lane cannot misalign after an upstream stall.

Parameters:
- GAP_LIMIT, 4: maximum consecutive valid_in-low cycles tolerated mid-word before the partial word is discarded. Legal range 1..15.

Ports:
- clk4f  input  1  byte-rate clock; all logic on rising edge.
- reset_L  input  1  asynchronous active-low reset.
- valid_in  input  1  byte qualifier; byte accepted on a rising edge with valid_in=1.
- data_in  input  8  input byte.
- valid_out  output  1  one-cycle pulse; data_out holds a new complete word.
- data_out  output  32  assembled word; holds its last value between pulses.
- gap_err  output  1  one-cycle pulse; a partial word was discarded by the watchdog.
- byte_cnt  output  2  number of bytes currently held in the partial word (0..3), for debug and verification.

Behaviour:
- Reset:
  - reset_L=0 asynchronously forces state=IDLE, byte_cnt=0, shift register=0, gap counter=0, valid_out=0, data_out=32'h0, gap_err=0.
  - Deassertion takes effect at the next rising edge.
  - Reset mid-word drops the partial word silently; no gap_err is raised.
- Packing order:
  - Byte k of a word (k=0..3) lands in data_out[31-8k -: 8].
  - Byte 0 lands in [31:24]; byte 3 lands in [7:0].
- State IDLE (byte_cnt=0):
  - valid_in=1: store byte into [31:24], byte_cnt becomes 1, go to COLLECT.
  - valid_in=0: stay in IDLE; the gap counter does not run.
- State COLLECT (byte_cnt 1..3):
  - valid_in=1 with byte_cnt<3: store byte, increment byte_cnt, clear gap counter.
  - valid_in=1 with byte_cnt=3 (4th byte):
    - Register the full word into data_out.
    - Assert valid_out on the following cycle (1-cycle latency from the edge sampling the 4th byte).
    - Return to IDLE with byte_cnt=0.
  - valid_in=0: increment gap counter.
    - If the counter reaches GAP_LIMIT, discard the partial word: byte_cnt=0, clear the shift register, pulse gap_err for one cycle, go to IDLE.
- Back-to-back operation:
  - A byte presented in the same cycle valid_out is high is accepted as byte 0 of the next word.
  - Sustained throughput is one word per 4 clk4f cycles with no bubble.
- Simultaneous events:
  - valid_in=1 on the cycle the gap counter would reach GAP_LIMIT: the byte wins.
  - The counter clears, no gap_err is raised, and the byte is packed normally.
- Output behaviour:
  - data_out changes only on the cycle valid_out is asserted.
  - valid_out and gap_err are never high together.
- data_in is ignored whenever valid_in=0; X on data_in with valid_in=0 must not propagate.
- Gap counter width is 4 bits. It saturates at GAP_LIMIT and cannot wrap.

Test Plan:
- Reset then stream bytes FF,FF,FF,FF,DD,DD,DD,DD with valid_in=1 each cycle -> valid_out pulses twice, 4 cycles apart; data_out=FFFFFFFF then DDDDDDDD; byte_cnt sequence 1,2,3,0,1,2,3,0.
- Bytes 00,00 then valid_in=0 for 2 cycles, then bytes 00,03 (GAP_LIMIT=4) -> single valid_out; data_out=00000003; gap_err stays 0.
- Bytes AA,BB then valid_in=0 for 4 cycles -> gap_err pulses once on the 4th idle edge; byte_cnt returns to 0. Then 11,22,33,44 -> data_out=11223344, with no stale AA/BB.
- Gap counter at GAP_LIMIT-1 and valid_in=1 with byte CC on the next edge -> no gap_err; CC packed in the correct lane.
- Assert reset_L=0 asynchronously between clock edges after 3 bytes -> outputs zero immediately, without waiting for a clock edge. After release, 4 bytes 12,34,56,78 -> data_out=12345678.
- Loopback: 32-to-8 serializer output feeds this block. Words FFFFFFFF, DDDDDDDD, 00000003 -> the same words appear on data_out in order, with matching valid_out count.

Source files
------------

// File: rtl/conv_8_32.sv
// Byte-to-word packer: collects four qualified bytes (first byte in the MSB lane) into a
// 32-bit word. A gap watchdog drops stale partial words after an upstream stall.
module conv_8_32 #(
  parameter int unsigned GAP_LIMIT = 4
) (
  input  logic        clk4f,
  input  logic        reset_L,
  input  logic        valid_in,
  input  logic [7:0]  data_in,
  output logic        valid_out,
  output logic [31:0] data_out,
  output logic        gap_err,
  output logic [1:0]  byte_cnt
);

  localparam logic [3:0] GapLimit = 4'(GAP_LIMIT);

  typedef enum logic {StIdle, StCollect} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] shift_q, shift_d;
  logic [3:0]  gap_q, gap_d;
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic        gap_err_q, gap_err_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    gap_d     = gap_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    gap_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        // The gap counter only runs mid-word.
        if (valid_in) begin
          shift_d = {data_in, 24'h0};
          cnt_d   = 2'd1;
          gap_d   = 4'd0;
          state_d = StCollect;
        end
      end
      StCollect: begin
        if (valid_in) begin
          // An arriving byte always beats a watchdog expiry on the same edge.
          gap_d = 4'd0;
          if (cnt_q == 2'd3) begin
            data_d  = {shift_q[31:8], data_in};
            valid_d = 1'b1;
            shift_d = 32'h0;
            cnt_d   = 2'd0;
            state_d = StIdle;
          end else begin
            case (cnt_q)
              2'd1:    shift_d[23:16] = data_in;
              2'd2:    shift_d[15:8]  = data_in;
              default: shift_d[31:24] = data_in;
            endcase
            cnt_d = cnt_q + 2'd1;
          end
        end else if ((gap_q + 4'd1) >= GapLimit) begin
          shift_d   = 32'h0;
          cnt_d     = 2'd0;
          gap_d     = 4'd0;
          gap_err_d = 1'b1;
          state_d   = StIdle;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk4f or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= StIdle;
      cnt_q     <= 2'd0;
      shift_q   <= 32'h0;
      gap_q     <= 4'd0;
      valid_q   <= 1'b0;
      data_q    <= 32'h0;
      gap_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      gap_q     <= gap_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      gap_err_q <= gap_err_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign gap_err   = gap_err_q;
  assign byte_cnt  = cnt_q;

endmodule
